// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - PC, instruction-memory and decode handshake bundle for fetch_queue
interface fetch_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]       pc_i;
  logic                   pc_valid_i;
  logic                   pc_ready_o;
  logic                   flush_i;
  logic                   imem_req_o;
  logic [WIDTH-1:0]       imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [WIDTH-1:0]       imem_rdata_i;
  logic [WIDTH-1:0]       instr_o;
  logic [WIDTH-1:0]       instr_pc_o;
  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [$clog2(DEPTH):0] level_o;

  // fetch_queue side
  modport slave (
    input  pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o, level_o
  );

  // PC stage / memory / decode side
  modport master (
    output pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o, level_o
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch with credit-limited memory requests and in-order FIFO
module fetch_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  // instruction FIFO: PC and word per entry
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    count;

  // PCs of live in-flight requests, oldest first
  logic [WIDTH-1:0] pend_mem [MAX_OUT];
  logic [PW-1:0]    pend_rd;
  logic [PW-1:0]    pend_wr;

  // live in-flight requests and stale responses still to be swallowed
  logic [CW-1:0]    out_cnt;
  logic [CW-1:0]    disc_cnt;

  logic space;
  logic req;
  logic accept;
  logic resp_keep;
  logic resp_drop;
  logic pop;

  // word alignment is checked upstream, so the low PC bits never reach memory
  logic unused_pc_low;
  assign unused_pc_low = ^bus.pc_i[1:0];

  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // credit check and handshake decode for this cycle
  always_comb begin
    space     = (int'(count) + int'(out_cnt) < DEPTH) &&
                (int'(out_cnt) + int'(disc_cnt) < MAX_OUT);
    req       = rst && bus.pc_valid_i && space && !bus.flush_i;
    accept    = req && bus.imem_gnt_i;
    resp_drop = bus.imem_rvalid_i && (disc_cnt != '0);
    resp_keep = bus.imem_rvalid_i && (disc_cnt == '0) && (out_cnt != '0) && !bus.flush_i;
    pop       = (count != '0) && bus.instr_ready_i && !bus.flush_i;
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = {bus.pc_i[WIDTH-1:2], 2'b00};
  assign bus.pc_ready_o    = accept;
  assign bus.instr_o       = instr_mem[rd_ptr];
  assign bus.instr_pc_o    = pc_mem[rd_ptr];
  assign bus.instr_valid_o = (count != '0);
  assign bus.level_o       = count;

  // instruction FIFO: push kept responses, pop on decode handshake, clear on redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (resp_keep) begin
        pc_mem[wr_ptr]    <= pend_mem[pend_rd];
        instr_mem[wr_ptr] <= bus.imem_rdata_i;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + LW'(resp_keep) - LW'(pop);
    end
  end

  // pending-PC FIFO and in-flight / discard accounting
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        pend_mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      // every live request becomes stale; a response landing now is swallowed here
      pend_rd  <= '0;
      pend_wr  <= '0;
      out_cnt  <= '0;
      disc_cnt <= disc_cnt + out_cnt -
                  CW'(bus.imem_rvalid_i && ((disc_cnt != '0) || (out_cnt != '0)));
    end else begin
      if (accept) begin
        pend_mem[pend_wr] <= bus.pc_i;
        pend_wr           <= pend_next(pend_wr);
      end
      if (resp_keep) begin
        pend_rd <= pend_next(pend_rd);
      end
      out_cnt <= out_cnt + CW'(accept) - CW'(resp_keep);
      if (resp_drop) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized self-checking bench for fetch_queue
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: delivered-but-unconsumed words, in-flight fetches {stale, pc}, memory queue
  logic [63:0] exp_q [$];
  logic [32:0] infl  [$];
  logic [31:0] mq    [$];
  logic        resp_en  = 1'b1;
  int          resp_pct = 100;

  // sampled DUT outputs and model expectations for the current cycle
  logic        o_req, o_ready, o_valid, e_req, e_ready, e_valid;
  logic [31:0] o_addr, o_instr, o_pc, e_addr;
  logic [2:0]  o_level, e_level;
  logic [63:0] e_head;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // one clock: sample at negedge, advance the model, then drive the memory response
  task automatic step();
    int          live;
    logic [32:0] f;
    @(negedge clk);
    o_req   = bus.imem_req_o;
    o_ready = bus.pc_ready_o;
    o_addr  = bus.imem_addr_o;
    o_valid = bus.instr_valid_o;
    o_instr = bus.instr_o;
    o_pc    = bus.instr_pc_o;
    o_level = bus.level_o;
    live = 0;
    foreach (infl[i]) if (!infl[i][32]) live++;
    e_req   = rst && bus.pc_valid_i && !bus.flush_i &&
              (exp_q.size() + live < DEPTH) && (infl.size() < MAX_OUT);
    e_ready = e_req && bus.imem_gnt_i;
    e_addr  = {bus.pc_i[31:2], 2'b00};
    e_valid = (exp_q.size() != 0);
    e_level = 3'(exp_q.size());
    e_head  = e_valid ? exp_q[0] : 64'h0;
    if (!rst) begin
      exp_q.delete();
      infl.delete();
      mq.delete();
    end else begin
      if (bus.imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
      if (bus.flush_i) begin
        if (bus.imem_rvalid_i && infl.size() > 0) void'(infl.pop_front());
        foreach (infl[i]) infl[i][32] = 1'b1;
        exp_q.delete();
      end else begin
        if (bus.imem_rvalid_i && infl.size() > 0) begin
          f = infl.pop_front();
          if (!f[32]) exp_q.push_back({f[31:0], bus.imem_rdata_i});
        end
        if (e_valid && bus.instr_ready_i) void'(exp_q.pop_front());
        if (e_ready) begin
          infl.push_back({1'b0, bus.pc_i});
          mq.push_back(e_addr);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid_i = (mq.size() > 0) && resp_en && ($urandom_range(99) < resp_pct);
    bus.imem_rdata_i  = bus.imem_rvalid_i ? mem_data(mq[0]) : $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.pc_valid_i    = 1'b0;
    bus.flush_i       = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.instr_ready_i = 1'b0;
    resp_en  = 1'b1;
    resp_pct = 100;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pc_i = 32'h0;
    bus.pc_valid_i = 1'b1;
    bus.imem_gnt_i = 1'b1;
    bus.instr_ready_i = 1'b1;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if ({o_req, o_ready, o_valid, o_level, o_instr, o_pc} !== 70'h0)
        $display("FAIL reset_state cyc=%0d got req=%b rdy=%b vld=%b lvl=%0d instr=%h pc=%h want all 0",
                 c, o_req, o_ready, o_valid, o_level, o_instr, o_pc);
      else n_pass++;
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0)
      $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", o_req, o_addr);
    else n_pass++;
  endtask

  task automatic test_stream();
    int first_acc = -1, first_val = -1, nv = 0;
    logic [31:0] exp_pc = 32'h0;
    do_reset();
    bus.pc_i = 32'h0; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      n_checks++;
      if ({o_req, o_ready, o_valid, o_level} !== {e_req, e_ready, e_valid, e_level})
        $display("FAIL stream_ctrl c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, o_req, o_ready, o_valid, o_level, e_req, e_ready, e_valid, e_level);
      else n_pass++;
      if (o_ready && first_acc < 0) first_acc = c;
      if (o_valid) begin
        if (first_val < 0) first_val = c;
        n_checks++;
        if (o_pc !== exp_pc || o_instr !== mem_data(exp_pc))
          $display("FAIL stream_data c=%0d got pc=%h instr=%h want pc=%h instr=%h",
                   c, o_pc, o_instr, exp_pc, mem_data(exp_pc));
        else n_pass++;
        exp_pc += 32'd4;
        nv++;
      end
      if (o_ready) bus.pc_i = bus.pc_i + 32'd4;
    end
    n_checks++;
    if (first_acc != 0 || first_val != first_acc + 2)
      $display("FAIL stream_latency got accept=%0d valid=%0d want accept=0 valid=2", first_acc, first_val);
    else n_pass++;
    n_checks++;
    if (nv != 12)
      $display("FAIL stream_throughput got %0d outputs want 12", nv);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0, pops = 0;
    logic resumed = 1'b0;
    do_reset();
    bus.pc_i = 32'h0; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if ({o_req, o_ready, o_valid, o_level} !== {e_req, e_ready, e_valid, e_level})
        $display("FAIL bp_ctrl c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, o_req, o_ready, o_valid, o_level, e_req, e_ready, e_valid, e_level);
      else n_pass++;
      if (o_ready) begin acc++; bus.pc_i = bus.pc_i + 32'd4; end
    end
    n_checks++;
    if (acc != 4 || o_req !== 1'b0 || o_level !== 3'd4)
      $display("FAIL bp_full got accepts=%0d req=%b level=%0d want 4/0/4", acc, o_req, o_level);
    else n_pass++;
    bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 12 && pops < 4; c++) begin
      step();
      if (o_req) resumed = 1'b1;
      if (o_valid) begin
        n_checks++;
        if (o_pc !== 32'(pops * 4) || o_instr !== mem_data(32'(pops * 4)))
          $display("FAIL bp_drain pop=%0d got pc=%h instr=%h want pc=%h", pops, o_pc, o_instr, pops * 4);
        else n_pass++;
        pops++;
      end
      if (o_ready) bus.pc_i = bus.pc_i + 32'd4;
    end
    n_checks++;
    if (pops != 4 || !resumed)
      $display("FAIL bp_resume got pops=%0d resumed=%b want 4/1", pops, resumed);
    else n_pass++;
  endtask

  task automatic test_grant_stall();
    logic got = 1'b0;
    do_reset();
    bus.pc_i = 32'h43; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b0; bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (o_req !== 1'b1 || o_ready !== 1'b0 || o_addr !== 32'h40)
        $display("FAIL stall_hold c=%0d got req=%b rdy=%b addr=%h want 1/0/00000040", c, o_req, o_ready, o_addr);
      else n_pass++;
    end
    bus.imem_gnt_i = 1'b1;
    step();
    n_checks++;
    if (o_ready !== 1'b1)
      $display("FAIL stall_accept got rdy=%b want 1", o_ready);
    else n_pass++;
    bus.pc_valid_i = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      step();
      if (o_valid) begin
        got = 1'b1;
        n_checks++;
        if (o_pc !== 32'h43 || o_instr !== mem_data(32'h40))
          $display("FAIL stall_data got pc=%h instr=%h want pc=00000043 instr=%h", o_pc, o_instr, mem_data(32'h40));
        else n_pass++;
      end
    end
    n_checks++;
    if (!got) $display("FAIL stall_timeout got no valid want one within 5 cycles");
    else n_pass++;
  endtask

  task automatic test_flush();
    int acc = 0;
    logic got = 1'b0;
    do_reset();
    resp_en = 1'b0;
    bus.pc_i = 32'h0; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 6 && acc < 2; c++) begin
      step();
      if (o_ready) begin acc++; bus.pc_i = bus.pc_i + 32'd4; end
    end
    n_checks++;
    if (acc != 2) $display("FAIL flush_setup got accepts=%0d want 2", acc);
    else n_pass++;
    bus.pc_valid_i = 1'b0;
    bus.flush_i = 1'b1;
    step();
    n_checks++;
    if (o_req !== 1'b0 || o_ready !== 1'b0)
      $display("FAIL flush_noreq got req=%b rdy=%b want 0/0", o_req, o_ready);
    else n_pass++;
    bus.flush_i = 1'b0;
    resp_en = 1'b1;
    bus.pc_i = 32'h100;
    bus.pc_valid_i = 1'b1;
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_level !== 3'd0)
      $display("FAIL flush_empty got vld=%b lvl=%0d want 0/0", o_valid, o_level);
    else n_pass++;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      n_checks++;
      if ({o_req, o_ready, o_valid, o_level} !== {e_req, e_ready, e_valid, e_level})
        $display("FAIL flush_ctrl c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, o_req, o_ready, o_valid, o_level, e_req, e_ready, e_valid, e_level);
      else n_pass++;
      if (o_ready) bus.pc_valid_i = 1'b0;
      if (o_valid) begin
        got = 1'b1;
        n_checks++;
        if (o_pc !== 32'h100 || o_instr !== mem_data(32'h100))
          $display("FAIL flush_first got pc=%h instr=%h want pc=00000100", o_pc, o_instr);
        else n_pass++;
      end
    end
    n_checks++;
    if (!got) $display("FAIL flush_timeout got no valid want pc 00000100 within 10 cycles");
    else n_pass++;
  endtask

  task automatic test_flush_coincident();
    logic [31:0] held;
    logic got = 1'b0;
    do_reset();
    bus.pc_i = 32'h200; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (o_ready) bus.pc_i = bus.pc_i + 32'd4;
    end
    held = bus.pc_i;
    bus.flush_i = 1'b1;
    step();
    n_checks++;
    if (o_req !== 1'b0 || o_ready !== 1'b0 || o_valid !== 1'b1)
      $display("FAIL coinc_flush got req=%b rdy=%b vld=%b want 0/0/1", o_req, o_ready, o_valid);
    else n_pass++;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (c == 0) begin
        n_checks++;
        if (o_valid !== 1'b0 || o_level !== 3'd0)
          $display("FAIL coinc_empty got vld=%b lvl=%0d want 0/0", o_valid, o_level);
        else n_pass++;
      end
      if (o_valid) begin
        got = 1'b1;
        n_checks++;
        if (o_pc !== held || o_instr !== mem_data(held))
          $display("FAIL coinc_first got pc=%h want pc=%h", o_pc, held);
        else n_pass++;
      end
      if (o_ready) bus.pc_i = bus.pc_i + 32'd4;
    end
    n_checks++;
    if (!got) $display("FAIL coinc_timeout got no valid within 8 cycles");
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    bus.pc_i = $urandom;
    for (int c = 0; c < 600; c++) begin
      bus.pc_valid_i    = ($urandom_range(99) < 80);
      bus.imem_gnt_i    = ($urandom_range(99) < 70);
      bus.instr_ready_i = ($urandom_range(99) < 60);
      bus.flush_i       = ($urandom_range(99) < 4);
      resp_pct          = 60;
      rst               = (c % 150 != 149);
      step();
      n_checks++;
      if ({o_req, o_ready, o_valid, o_level} !== {e_req, e_ready, e_valid, e_level})
        $display("FAIL rand_ctrl c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, o_req, o_ready, o_valid, o_level, e_req, e_ready, e_valid, e_level);
      else n_pass++;
      if (o_req) begin
        n_checks++;
        if (o_addr !== e_addr) $display("FAIL rand_addr c=%0d got %h want %h", c, o_addr, e_addr);
        else n_pass++;
      end
      if (o_valid) begin
        n_checks++;
        if ({o_pc, o_instr} !== e_head)
          $display("FAIL rand_head c=%0d got pc=%h instr=%h want pc=%h instr=%h",
                   c, o_pc, o_instr, e_head[63:32], e_head[31:0]);
        else n_pass++;
      end
      if (o_ready || bus.flush_i)
        bus.pc_i = ($urandom_range(1) == 0) ? bus.pc_i + 32'd4 : $urandom;
    end
    rst = 1'b1;
  endtask

  initial begin
    bus.pc_i = '0; bus.pc_valid_i = 1'b0; bus.flush_i = 1'b0; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.instr_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_grant_stall();
    test_flush();
    test_flush_coincident();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got cycle=%0d want completion before time limit", cyc);
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly downstream of the PC stage. Takes the current PC, issues word requests to instruction memory over a req/gnt/rvalid handshake with up to MAX_OUT requests in flight, and buffers returned instructions with their PCs in a DEPTH-entry in-order FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect (flush) discards everything queued or in flight. The PC register advances only when pc_ready_o is high.

## Interface
- WIDTH, 32: address/instruction width.
- DEPTH, 4: instruction FIFO entries; power of two, at least 2.
- MAX_OUT, 2: maximum outstanding memory requests; at least 1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets all state.
- pc_i  in  WIDTH  PC to fetch, driven by the PC stage.
- pc_valid_i  in  1  pc_i is a valid fetch address.
- pc_ready_o  out  1  request for pc_i accepted this cycle; PC stage may advance.
- flush_i  in  1  redirect: discard queued and in-flight fetches.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  WIDTH  request address, {pc_i[WIDTH-1:2],2'b00}.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response data valid; responses return in request order.
- imem_rdata_i  in  WIDTH  response instruction.
- instr_o  out  WIDTH  instruction at FIFO head.
- instr_pc_o  out  WIDTH  PC of instr_o.
- instr_valid_o  out  1  FIFO non-empty.
- instr_ready_i  in  1  decode consumes head when instr_valid_o is also high.
- level_o  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- State: FIFO storage (pc, instr) with read/write pointers and count; pending-PC FIFO of MAX_OUT entries; outstanding counter `out`; discard counter `disc`.
- Credit: space = (count + out < DEPTH) and (out + disc < MAX_OUT). A slot is reserved for every in-flight request, so a response never overflows the FIFO.
- Request: imem_req_o = rst && pc_valid_i && space && !flush_i. Combinational; address is a pure function of pc_i.
- Accept: when imem_req_o && imem_gnt_i, pc_ready_o=1, pc_i is pushed to the pending-PC FIFO, and out increments.
- Response: on imem_rvalid_i:
  - if disc>0, disc decrements and the data is dropped;
  - otherwise the head pending PC is popped, out decrements, and {pc, imem_rdata_i} is pushed to the FIFO.
- Pop: instr_valid_o && instr_ready_i advances the read pointer.
- Same-cycle push and pop are both applied; count is unchanged.
- Flush (flush_i=1):
  - FIFO count and pointers clear.
  - Pending-PC FIFO clears.
  - disc <= disc + out, minus 1 if an rvalid arrives this cycle; that response counts against out or disc, and is dropped either way.
  - out <= 0.
  - No request is issued and no pop is reported.
  - Memory tolerates request withdrawal in the flush cycle.
- A flush has priority over push, pop and accept in the same cycle.
- pc_i[1:0] is ignored; alignment faults are handled upstream.
- Counters never wrap: out+disc <= MAX_OUT and count+out <= DEPTH are invariants.

## Timing
- Reset values: instr_valid_o=0, instr_o=0, instr_pc_o=0, level_o=0, imem_req_o=0, pc_ready_o=0, out=disc=0. Storage clears to 0.
- Latency: accept at cycle N, rvalid earliest at N+1, instr_valid_o high at N+2.
- Throughput: one instruction per cycle with gnt=1, 1-cycle response, and ready=1.
- instr_o, instr_pc_o and instr_valid_o are driven from registers and the head read; there is no combinational path from imem_* to instr_*.
- pc_ready_o and imem_req_o depend combinationally on pc_valid_i, flush_i, imem_gnt_i and registered state.
- Reset mid-operation: all state clears next edge; later responses to pre-reset requests are not expected by this block (memory is reset concurrently).
- After a flush, instr_valid_o=0 in the following cycle. A new request may issue that same next cycle if credit allows.

## Test plan
- Reset: hold rst=0 for 2 cycles with pc_valid_i=1 and gnt=1 -> imem_req_o=0, instr_valid_o=0, level_o=0 throughout; first request issues in the first cycle with rst=1.
- Stream: pc 0x0,0x4,0x8,… with gnt=1, rvalid one cycle after accept, instr_ready_i=1 -> instr_pc_o=0x0 appears at accept+2, then one instruction per cycle in order with matching rdata.
- Backpressure: instr_ready_i=0, DEPTH=4, MAX_OUT=2 -> exactly 4 accepts, then imem_req_o=0 and level_o=4. Set ready=1 -> 4 pops in order; requests resume.
- Grant stall: gnt=0 for 3 cycles -> imem_req_o held with imem_addr_o stable and pc_ready_o=0; on gnt=1, one accept occurs.
- Flush with 2 outstanding: flush_i pulse, then both stale rvalids arrive -> both dropped. Next fetch at pc 0x100 delivers instr_pc_o=0x100 as the first valid output.
- Flush coincident with rvalid, pop and gnt: queue empties, the response is dropped, nothing is accepted, and instr_valid_o=0 next cycle.
